// File: rtl/as_pack.sv
// Shared LSU types: operation encoding, access sizes, FSM states and lane helpers.
package as_pack;

    localparam int reg_width   = 64;
    localparam int lsuop_width = 4;

    typedef enum logic [lsuop_width-1:0] {
        LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
    } lsu_op_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

    // Unused encodings fall through to a doubleword load.
    function automatic lsu_size_e op_size(input lsu_op_e op);
        case (op)
            LB, LBU, SB: op_size = SZ_B;
            LH, LHU, SH: op_size = SZ_H;
            LW, LWU, SW: op_size = SZ_W;
            default:     op_size = SZ_D;
        endcase
    endfunction

    function automatic logic op_signed(input lsu_op_e op);
        op_signed = (op == LB) || (op == LH) || (op == LW) || (op == LD);
    endfunction

    function automatic logic op_store(input lsu_op_e op);
        op_store = (op == SB) || (op == SH) || (op == SW) || (op == SD);
    endfunction

    function automatic logic [7:0] size_mask(input lsu_size_e sz);
        case (sz)
            SZ_B:    size_mask = 8'h01;
            SZ_H:    size_mask = 8'h03;
            SZ_W:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] align_low(input logic [2:0] lo, input lsu_size_e sz);
        case (sz)
            SZ_B:    align_low = lo;
            SZ_H:    align_low = {lo[2:1], 1'b0};
            SZ_W:    align_low = {lo[2], 2'b00};
            default: align_low = 3'b000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] lo, input lsu_size_e sz);
        misaligned = (align_low(lo, sz) != lo);
    endfunction

endpackage

// File: rtl/as_lsu_align.sv
// Combinational byte-lane steering: stores shift left into the lane,
// loads shift right out of the lane and then sign/zero extend.
module as_lsu_align
    import as_pack::*;
(
    input  logic                 store_i,
    input  logic [2:0]           lane_i,
    input  lsu_size_e            size_i,
    input  logic                 sign_i,
    input  logic [63:0]          data_i,
    output logic [reg_width-1:0] data_o
);

    logic [5:0]  sh;
    logic [63:0] shr;

    assign sh  = {lane_i, 3'b000};
    assign shr = data_i >> sh;

    always_comb begin
        data_o = '0;
        if (store_i) begin
            data_o = data_i << sh;
        end else begin
            case (size_i)
                SZ_B:    data_o = {{56{sign_i & shr[7]}},  shr[7:0]};
                SZ_H:    data_o = {{48{sign_i & shr[15]}}, shr[15:0]};
                SZ_W:    data_o = {{32{sign_i & shr[31]}}, shr[31:0]};
                default: data_o = shr;
            endcase
        end
    end

endmodule

// File: rtl/as_lsu.sv
// Load/store unit: one outstanding bus access, req/gnt then rvalid handshake.
// Define AS_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking them.
module as_lsu
    import as_pack::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [lsuop_width-1:0] op_i,
    input  logic [reg_width-1:0]   addr_i,
    input  logic [reg_width-1:0]   wdata_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [reg_width-1:0]   mem_addr_o,
    output logic [7:0]             mem_be_o,
    output logic [63:0]            mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [63:0]            mem_rdata_i,
    output logic                   rsp_valid_o,
    output logic [reg_width-1:0]   rdata_o,
    output logic                   misalign_o,
    output logic                   buserr_o
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    lsu_op_e              op_q, op_in;
    logic [reg_width-1:0] addr_q, wdata_q, rdata_q, load_data;
    logic                 misalign_q, buserr_q;
    logic                 req_fire, trap_hit, timeout_hit, enter_resp;
    lsu_size_e            size_in, size_q;

    assign op_in       = lsu_op_e'(op_i);
    assign size_in     = op_size(op_in);
    assign size_q      = op_size(op_q);
    assign req_fire    = req_valid_i && (state_q == IDLE);
    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);
    assign enter_resp  = (state_d == RESP) && (state_q != RESP);

`ifdef AS_LSU_MISALIGN_TRAP_EN
    assign trap_hit = misaligned(addr_i[2:0], size_in);
`else
    assign trap_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_fire) state_d = trap_hit ? RESP : REQ;
            REQ:  if (mem_gnt_i) state_d = op_store(op_q) ? RESP : WAIT;
            WAIT: if (mem_rvalid_i || timeout_hit) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Low address bits are forced to natural alignment; in the trap
            // build a misaligned request never reaches the bus anyway.
            if (req_fire) begin
                op_q    <= op_in;
                addr_q  <= {addr_i[reg_width-1:3], align_low(addr_i[2:0], size_in)};
                wdata_q <= wdata_i;
            end
            if (state_q == WAIT && !mem_rvalid_i)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
            if (enter_resp) begin
                misalign_q <= (state_q == IDLE);
                buserr_q   <= (state_q == WAIT) && !mem_rvalid_i;
                rdata_q    <= (state_q == WAIT && mem_rvalid_i) ? load_data : '0;
            end
        end
    end

    as_lsu_align u_store_align (
        .store_i (1'b1),
        .lane_i  (addr_q[2:0]),
        .size_i  (size_q),
        .sign_i  (1'b0),
        .data_i  (wdata_q),
        .data_o  (mem_wdata_o)
    );

    as_lsu_align u_load_align (
        .store_i (1'b0),
        .lane_i  (addr_q[2:0]),
        .size_i  (size_q),
        .sign_i  (op_signed(op_q)),
        .data_i  (mem_rdata_i),
        .data_o  (load_data)
    );

    assign req_ready_o = (state_q == IDLE);
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = (state_q == REQ) && op_store(op_q);
    assign mem_addr_o  = {addr_q[reg_width-1:3], 3'b000};
    assign mem_be_o    = size_mask(size_q) << addr_q[2:0];
    assign rsp_valid_o = (state_q == RESP);
    assign rdata_o     = rdata_q;
    assign misalign_o  = misalign_q;
    assign buserr_o    = buserr_q;

endmodule

// File: tb/tb_as_lsu.sv
// Scoreboard bench for as_lsu: expected responses queued at issue, compared at rsp_valid.
module tb_as_lsu;
    import as_pack::*;

    typedef struct packed {
        logic [63:0] rdata;
        logic        misalign;
        logic        buserr;
    } rsp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid_i = 1'b0;
    logic                   req_ready_o;
    logic [lsuop_width-1:0] op_i = '0;
    logic [63:0]            addr_i = '0, wdata_i = '0;
    logic                   mem_req_o, mem_we_o;
    logic [63:0]            mem_addr_o, mem_wdata_o;
    logic [7:0]             mem_be_o;
    logic                   mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [63:0]            mem_rdata_i = '0;
    logic                   rsp_valid_o, misalign_o, buserr_o;
    logic [63:0]            rdata_o;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int   errors = 0;
    int   checks = 0;

    as_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
        .buserr_o(buserr_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rsp_valid_o) obs_q.push_back({rdata_o, misalign_o, buserr_o});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input lsu_op_e op, input logic [63:0] a, input logic [63:0] wd);
        op_i = op; addr_i = a; wdata_i = wd; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({req_ready_o, mem_req_o, rsp_valid_o, misalign_o, buserr_o} !== 5'b10000 || rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL reset: got rdy/req/rsp/mis/err=%b rdata=%h want 10000 and 0",
                     {req_ready_o, mem_req_o, rsp_valid_o, misalign_o, buserr_o}, rdata_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        lsu_op_e     ops[3] = '{SW, SB, SD};
        logic [63:0] adr[3] = '{64'h1004, 64'h1007, 64'h1000};
        logic [63:0] wd[3]  = '{64'hDEADBEEF, 64'h55AB, 64'h0123456789ABCDEF};
        logic [7:0]  be[3]  = '{8'hF0, 8'h80, 8'hFF};
        logic [63:0] wl[3]  = '{64'hDEADBEEF_00000000, 64'hAB00_0000_0000_0000, 64'h0123456789ABCDEF};
        rsp_t o, e;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], adr[i], wd[i]);
            exp_q.push_back({64'h0, 1'b0, 1'b0});
            checks++;
            if ({mem_req_o, mem_we_o} !== 2'b11 || mem_addr_o !== 64'h1000 ||
                mem_be_o !== be[i] || mem_wdata_o !== wl[i]) begin
                errors++;
                $display("FAIL store_bus[%0d]: req/we=%b addr=%h be=%h wdata=%h want 11 1000 %h %h",
                         i, {mem_req_o, mem_we_o}, mem_addr_o, mem_be_o, mem_wdata_o, be[i], wl[i]);
            end
            mem_gnt_i = 1'b1;
            tick();
            mem_gnt_i = 1'b0;
            checks++;
            if (rsp_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL store_latency[%0d]: rsp_valid=%b want 1 two cycles after accept", i, rsp_valid_o);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL store_rsp[%0d]: no response, want %h", i, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL store_rsp[%0d]: got %h want %h", i, o, e);
                end
            end
        end
    endtask

    task automatic test_load_ext();
        lsu_op_e     ops[6] = '{LB, LBU, LH, LHU, LW, LWU};
        logic [63:0] adr[6] = '{64'h2003, 64'h2003, 64'h2006, 64'h2006, 64'h2004, 64'h2004};
        logic [63:0] rd[6]  = '{64'h80000000, 64'h80000000, 64'h8001_0000_0000_0000,
                                64'h8001_0000_0000_0000, 64'h89ABCDEF_00000000, 64'h89ABCDEF_00000000};
        logic [63:0] ex[6]  = '{64'hFFFFFFFFFFFFFF80, 64'h80, 64'hFFFFFFFFFFFF8001,
                                64'h8001, 64'hFFFFFFFF89ABCDEF, 64'h89ABCDEF};
        rsp_t o, e;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], adr[i], 64'h0);
            exp_q.push_back({ex[i], 1'b0, 1'b0});
            mem_gnt_i = 1'b1;
            tick();
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b1; mem_rdata_i = rd[i];
            checks++;
            if (rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL load_early[%0d]: rsp_valid=%b want 0 in WAIT", i, rsp_valid_o);
            end
            tick();
            mem_rvalid_i = 1'b0;
            checks++;
            if (rsp_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL load_latency[%0d]: rsp_valid=%b want 1 three cycles after accept", i, rsp_valid_o);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL load_rsp[%0d]: no response, want %h", i, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL load_rsp[%0d]: got %h want %h", i, o, e);
                end
            end
        end
    endtask

    task automatic test_gnt_delay();
        rsp_t o, e;
        send(LD, 64'h4000, 64'h0);
        exp_q.push_back({64'h0123456789ABCDEF, 1'b0, 1'b0});
        for (int c = 0; c < 5; c++) begin
            if (c == 4) mem_gnt_i = 1'b1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 64'h4000 || mem_be_o !== 8'hFF) begin
                errors++;
                $display("FAIL gnt_hold[%0d]: req=%b we=%b addr=%h be=%h want 1 0 4000 ff",
                         c, mem_req_o, mem_we_o, mem_addr_o, mem_be_o);
            end
            tick();
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0123456789ABCDEF;
        tick();
        mem_rvalid_i = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL gnt_delay_pulses: got %0d responses want 1", obs_q.size());
            obs_q.delete();
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL gnt_delay_rsp: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_misalign();
        rsp_t o, e;
        send(LW, 64'h3002, 64'h0);
`ifdef AS_LSU_MISALIGN_TRAP_EN
        exp_q.push_back({64'h0, 1'b1, 1'b0});
        checks++;
        if (mem_req_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_trap: req=%b rsp=%b want 0 1", mem_req_o, rsp_valid_o);
        end
`else
        exp_q.push_back({64'hFFFFFFFF80000001, 1'b0, 1'b0});
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h3000 || mem_be_o !== 8'h0F) begin
            errors++;
            $display("FAIL misalign_mask: req=%b addr=%h be=%h want 1 3000 0f", mem_req_o, mem_addr_o, mem_be_o);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFFFFFF_80000001;
        tick();
        mem_rvalid_i = 1'b0;
`endif
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL misalign_rsp: no response, want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL misalign_rsp: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_timeout();
        rsp_t o, e;
        int   waited = 0;
        send(LW, 64'h5000, 64'h0);
        exp_q.push_back({64'h0, 1'b0, 1'b1});
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        while (!rsp_valid_o && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (waited != 8) begin
            errors++;
            $display("FAIL timeout_cycles: RESP after %0d cycles in WAIT want 8", waited);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL timeout_rsp: no response, want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL timeout_rsp: got %h want %h", o, e);
            end
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rvalid_i = 1'b0;
        tick(); tick();
        checks++;
        if (obs_q.size() != 0 || req_ready_o !== 1'b1 || buserr_o !== 1'b1 || rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL late_rvalid: rsps=%0d rdy=%b err=%b rdata=%h want 0 1 1 0",
                     obs_q.size(), req_ready_o, buserr_o, rdata_o);
        end
    endtask

    task automatic test_reset_mid();
        send(LH, 64'h6002, 64'h0);
        checks++;
        if (mem_be_o !== 8'h0C) begin
            errors++;
            $display("FAIL lh_be: be=%h want 0c", mem_be_o);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || buserr_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b rsp=%b err=%b req=%b want 1 0 0 0",
                     req_ready_o, rsp_valid_o, buserr_o, mem_req_o);
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1234;
        tick();
        mem_rvalid_i = 1'b0;
        tick(); tick();
        checks++;
        if (obs_q.size() != 0 || rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_drop: rsps=%0d rdata=%h want 0 0", obs_q.size(), rdata_o);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_ext();
        test_gnt_delay();
        test_misalign();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: expected left=%0d observed left=%0d", exp_q.size(), obs_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/as_lsu.md
AS_LSU -- requirements
Module: as_lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles in WAIT before a bus error; 0 disables the timeout.
REQ-002 The block SHALL have these ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_valid_i  input  1  execute stage presents a memory operation.
- req_ready_o  output  1  block can accept a request.
- op_i  input  lsuop_width  operation: LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD.
- addr_i  input  reg_width  effective address, equal to the ALU sum result.
- wdata_i  input  reg_width  store data, right-aligned.
- mem_req_o  output  1  bus request.
- mem_we_o  output  1  bus write enable.
- mem_addr_o  output  reg_width  doubleword-aligned bus address.
- mem_be_o  output  8  byte enables.
- mem_wdata_o  output  64  lane-shifted store data.
- mem_gnt_i  input  1  bus grant.
- mem_rvalid_i  input  1  read data valid.
- mem_rdata_i  input  64  read data.
- rsp_valid_o  output  1  one-cycle completion pulse.
- rdata_o  output  reg_width  extended load result.
- misalign_o  output  1  misaligned-access flag, valid with rsp_valid_o.
- buserr_o  output  1  timeout flag, valid with rsp_valid_o.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WAIT and RESP, with req_ready_o high only in IDLE.
REQ-004 A request SHALL be captured (op, addr, wdata) on req_valid_i and req_ready_o, moving IDLE->REQ, or IDLE->RESP when misaligned and the trap feature is enabled.
REQ-005 In REQ, mem_req_o SHALL be held high with stable address, be, we and wdata until the cycle mem_gnt_i is high.
REQ-006 On grant, a store SHALL go REQ->RESP and a load SHALL go REQ->WAIT.
REQ-007 In WAIT, mem_rvalid_i SHALL capture mem_rdata_i and move to RESP; rvalid in any other state SHALL be ignored.
REQ-008 In WAIT, a counter SHALL increment every cycle; reaching TIMEOUT_CYCLES without rvalid SHALL move to RESP with buserr_o=1 and rdata_o=0.
REQ-009 In RESP, rsp_valid_o SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; minimum latency is accept->rsp of 2 cycles for a store and 3 cycles for a load, with gnt immediate and rvalid on the next cycle.
REQ-010 Byte ordering SHALL be little-endian: mem_addr_o = {addr[reg_width-1:3], 3'b0}, lane = addr[2:0], mem_be_o = size mask << lane, mem_wdata_o = wdata << (8*lane).
REQ-011 Load results SHALL be shifted right by 8*lane, then sign-extended (LB/LH/LW/LD) or zero-extended (LBU/LHU/LWU) to reg_width.
REQ-012 Misalignment SHALL be: H with addr[0]=1; W with addr[1:0]!=0; D with addr[2:0]!=0; bytes are never misaligned.
REQ-013 rdata_o, misalign_o and buserr_o SHALL hold their values until the next RESP.

Reset
REQ-014 rst_i SHALL force IDLE and clear the counter, rsp_valid_o, mem_req_o, misalign_o, buserr_o and rdata_o to 0 on the next edge, including mid-transaction; the outstanding bus response is then dropped.

Configuration
REQ-015 With AS_LSU_MISALIGN_TRAP_EN defined, a misaligned request SHALL issue no bus request and go to RESP with misalign_o=1 and rdata_o=0.
REQ-016 Without AS_LSU_MISALIGN_TRAP_EN, addr low bits SHALL be masked to natural alignment before use, and misalign_o SHALL be tied to 0.

Structure
REQ-017 lsuop_width, the lsu_op_e enum, the size encoding and reg_width SHALL live in as_pack.
REQ-018 The lane shift and extension logic SHALL be a combinational sub-module, as_lsu_align, instantiated once for store and once for load.

Verification
REQ-019 SW at addr 0x1004, wdata 0xDEADBEEF, gnt immediate -> mem_addr_o=0x1000, mem_be_o=0xF0, mem_wdata_o=0xDEADBEEF_00000000, rsp_valid_o 2 cycles after accept.
REQ-020 LB at 0x2003 with rdata 0x00000000_80000000 and rvalid 1 cycle after gnt -> rdata_o=0xFFFFFFFFFFFFFF80; LBU of the same -> 0x80.
REQ-021 LD with gnt delayed 4 cycles -> mem_req_o and outputs stable for 5 cycles, and exactly one rsp_valid_o pulse.
REQ-022 LW at 0x3002 -> with the macro, no mem_req_o and misalign_o=1; without it, mem_be_o=0x0F and misalign_o=0.
REQ-023 TIMEOUT_CYCLES=8 with no rvalid -> buserr_o=1 at RESP; a late rvalid in IDLE is ignored.
REQ-024 rst_i asserted in WAIT -> IDLE and req_ready_o=1 next cycle, with no rsp_valid_o.
